// File: rtl/ni_link_arbiter_if.sv
// Flit handshake bundle between the requesters, the link arbiter and the router port.
interface ni_link_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned FLIT_W = 8
);
    logic [N_REQ*FLIT_W-1:0] in_flit;
    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ-1:0]        in_last;
    logic [N_REQ-1:0]        in_ready;
    logic [FLIT_W-1:0]       out_flit;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;

    modport master (
        input  in_flit, in_valid, in_last, out_ready,
        output in_ready, out_flit, out_valid, out_last
    );

    modport slave (
        output in_flit, in_valid, in_last, out_ready,
        input  in_ready, out_flit, out_valid, out_last
    );
endinterface

// File: rtl/ni_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one flit link among N_REQ sources,
// with a registered output stage and a sticky malformed-header flag.
module ni_link_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned FLIT_W     = 8,
    parameter logic [5:0]  HEADER_TAG = 6'b101111,
    localparam int unsigned GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ni_link_arbiter_if.master    link,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 err_hdr
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       pick;
    logic                pick_found;
    int unsigned         idx;
    logic [FLIT_W-1:0]   sel_flit;
    logic                sel_valid;
    logic                sel_last;
    logic                can_take;
    logic                accept;
    logic                first_flit;

    // Round-robin search starting just after the most recently granted requester.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last_grant) + i) % N_REQ;
            if (!pick_found && link.in_valid[GW'(idx)]) begin
                pick       = GW'(idx);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_flit  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (GW'(i) == grant_id) begin
                sel_flit  = link.in_flit[i*FLIT_W +: FLIT_W];
                sel_valid = link.in_valid[i];
                sel_last  = link.in_last[i];
            end
        end
    end

    assign can_take = ~link.out_valid | link.out_ready;
    assign accept   = (state == LOCKED) && sel_valid && can_take;
    assign busy     = (state == LOCKED);

    always_comb begin
        link.in_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            link.in_ready[i] = (state == LOCKED) && (GW'(i) == grant_id) && can_take;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found)         state_nxt = LOCKED;
            LOCKED:  if (accept && sel_last) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id       <= '0;
            last_grant     <= GW'(N_REQ - 1);
            first_flit     <= 1'b1;
            err_hdr        <= 1'b0;
            link.out_flit  <= '0;
            link.out_valid <= 1'b0;
            link.out_last  <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant_id   <= pick;
                first_flit <= 1'b1;
            end
            if (accept) begin
                link.out_flit  <= sel_flit;
                link.out_last  <= sel_last;
                link.out_valid <= 1'b1;
                if (first_flit && sel_flit[7:2] != HEADER_TAG) err_hdr <= 1'b1;
                // A tail flit re-arms header checking for the next packet.
                first_flit <= sel_last;
                if (sel_last) last_grant <= grant_id;
            end else if (link.out_valid && link.out_ready) begin
                link.out_valid <= 1'b0;
            end
        end
    end

endmodule
